// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the combinational instruction
// memory address and registers the returned word into the IF/ID register.
module fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter int          MEM_WORDS = 16,
  parameter logic [15:0] HALT_WORD = 16'hFFFF,
  parameter logic [15:0] NOP_WORD  = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] instrAdr,
  input  logic [15:0] instrData,
  input  logic        stall,
  input  logic        branchTaken,
  input  logic [15:0] branchTarget,
  output logic [15:0] fetchInstr,
  output logic [15:0] fetchPC,
  output logic        fetchValid,
  output logic        halted,
  output logic [15:0] fetchCount
);

  localparam logic [15:0] PC_MASK = 16'(MEM_WORDS - 1);
  localparam logic [15:0] PC_RST  = RESET_PC & PC_MASK;

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] fpc_q, fpc_d;
  logic        vld_q, vld_d;
  logic [15:0] cnt_q, cnt_d;

  function automatic logic [15:0] wrap_pc(input logic [15:0] a);
    return a & PC_MASK;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= PC_RST;
      instr_q <= NOP_WORD;
      fpc_q   <= 16'h0000;
      vld_q   <= 1'b0;
      cnt_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      fpc_q   <= fpc_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    fpc_d   = fpc_q;
    vld_d   = vld_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      BOOT: begin
        if (branchTaken) pc_d = wrap_pc(branchTarget);
        state_d = RUN;
      end
      RUN: begin
        // Redirect wins over stall so a taken branch is never lost.
        if (branchTaken) begin
          pc_d    = wrap_pc(branchTarget);
          vld_d   = 1'b0;
          instr_d = NOP_WORD;
        end else if (!stall) begin
          instr_d = instrData;
          fpc_d   = pc_q;
          vld_d   = 1'b1;
          cnt_d   = sat_inc(cnt_q);
          if (instrData == HALT_WORD) state_d = HALT;
          else                        pc_d    = wrap_pc(pc_q + 16'd1);
        end
      end
      HALT: begin
        if (branchTaken) begin
          pc_d    = wrap_pc(branchTarget);
          vld_d   = 1'b0;
          instr_d = NOP_WORD;
          state_d = RUN;
        end else if (!stall) begin
          vld_d   = 1'b0;
          instr_d = NOP_WORD;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  assign instrAdr   = pc_q;
  assign fetchInstr = instr_q;
  assign fetchPC    = fpc_q;
  assign fetchValid = vld_q;
  assign halted     = (state_q == HALT);
  assign fetchCount = cnt_q;

endmodule
